laser_slot_sched: RTL and testbench

- Owns the laser table consumed by the game renderer: allocates laser slots on fire requests, advances every active laser once per frame tick, and retires lasers on hit or screen exit.
- Slot 0 is reserved for the cannon laser. Slots 1..NSLOT-1 form the enemy laser pool.
- Sits between the game FSM (fire and hit events) and the pixel-compare logic (slot readback).

---
 rtl/laser_slot_sched.sv | 159 +++++++++++++++
 tb/tb_laser_slot_sched.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_slot_sched.sv
// Laser slot table: allocates, advances and retires laser entries.
// Slot 0 is the cannon laser; slots 1..NSLOT-1 are the enemy pool.
module laser_slot_sched #(
  parameter int          NSLOT       = 40,
  parameter int          VMAX        = 480,
  parameter int          LASER_LEN   = 20,
  parameter int          CANNON_VPOS = 440,
  parameter logic [11:0] C_COLOR     = 12'h0F0,
  parameter logic [11:0] E_COLOR     = 12'hF00
) (
  input  logic             clk25M,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [3:0]       speed,
  input  logic             fire_c_req,
  input  logic [11:0]      fire_c_hpos,
  output logic             fire_c_ack,
  input  logic             fire_e_req,
  input  logic [11:0]      fire_e_hpos,
  input  logic [11:0]      fire_e_vpos,
  output logic             fire_e_ack,
  input  logic             hit_valid,
  input  logic [5:0]       hit_slot,
  input  logic [5:0]       rd_slot,
  output logic [39:0]      rd_entry,
  output logic [NSLOT-1:0] active,
  output logic             busy,
  output logic             overrun
);

  localparam logic [5:0]  LAST   = 6'(NSLOT - 1);
  localparam logic [12:0] VMAX13 = 13'(VMAX);
  localparam logic [12:0] LEN13  = 13'(LASER_LEN);
  localparam logic [11:0] CV12   = 12'(CANNON_VPOS);
  localparam logic [6:0]  NS7    = 7'(NSLOT);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t      state, state_n;
  logic [5:0]  idx, idx_n;
  logic [39:0] tbl [NSLOT];

  logic        c_acc, e_acc, e_found;
  logic [5:0]  e_slot;
  logic [12:0] cur_v, sp13, sum_e;
  logic [11:0] new_v;
  logic        sw_clr;

  // State register for the sweep sequencer.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: one slot per cycle while sweeping.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          state_n = SWEEP;
          idx_n   = '0;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (idx == LAST) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + 6'd1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Lowest free enemy slot; scanning downward leaves the smallest index.
  always_comb begin
    e_found = 1'b0;
    e_slot  = '0;
    for (int i = NSLOT - 1; i >= 1; i--) begin
      if (!tbl[i][39]) begin
        e_found = 1'b1;
        e_slot  = 6'(i);
      end
    end
  end

  // Fire acceptance is only possible while idle and not mid-ack.
  always_comb begin
    c_acc = (state == IDLE) && fire_c_req && !tbl[0][39] && !fire_c_ack;
    e_acc = (state == IDLE) && fire_e_req && e_found && !fire_e_ack;
  end

  // Motion of the slot under the sweep pointer, 13-bit so nothing wraps.
  always_comb begin
    cur_v = {1'b0, tbl[idx][35:24]};
    sp13  = {9'd0, speed};
    sum_e = cur_v + sp13 + LEN13;
    if (idx == 6'd0) begin
      sw_clr = cur_v < sp13;
      new_v  = tbl[idx][35:24] - {8'd0, speed};
    end else begin
      sw_clr = sum_e > VMAX13;
      new_v  = tbl[idx][35:24] + {8'd0, speed};
    end
  end

  // Table update: sweep, then hit clear, then allocation take priority.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (state == SWEEP && idx == 6'(i) && tbl[i][39]) begin
          if (sw_clr) tbl[i] <= '0;
          else        tbl[i][35:24] <= new_v;
        end
        if (hit_valid && hit_slot == 6'(i)) tbl[i] <= '0;
        if (i == 0 && c_acc)
          tbl[i] <= {1'b1, 3'b0, CV12, fire_c_hpos, C_COLOR};
        if (i != 0 && e_acc && e_slot == 6'(i))
          tbl[i] <= {1'b1, 3'b0, fire_e_vpos, fire_e_hpos, E_COLOR};
      end
    end
  end

  // One-cycle ack and overrun pulses.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      fire_c_ack <= 1'b0;
      fire_e_ack <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      fire_c_ack <= c_acc;
      fire_e_ack <= e_acc;
      overrun    <= frame_tick && (state == SWEEP);
    end
  end

  // Combinational readback of one entry and of all enable bits.
  always_comb begin
    rd_entry = '0;
    if ({1'b0, rd_slot} < NS7) rd_entry = tbl[rd_slot];
    for (int i = 0; i < NSLOT; i++) active[i] = tbl[i][39];
  end

endmodule

// File: tb/tb_laser_slot_sched.sv
// Self-checking bench for laser_slot_sched.
// Fire expectations go through a scoreboard queue popped on ack.
module tb_laser_slot_sched;

  logic        clk25M = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  speed;
  logic        fire_c_req;
  logic [11:0] fire_c_hpos;
  logic        fire_c_ack;
  logic        fire_e_req;
  logic [11:0] fire_e_hpos;
  logic [11:0] fire_e_vpos;
  logic        fire_e_ack;
  logic        hit_valid;
  logic [5:0]  hit_slot;
  logic [5:0]  rd_slot;
  logic [39:0] rd_entry;
  logic [39:0] active;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          slot;
    logic [39:0] ent;
  } exp_t;

  exp_t sb[$];

  laser_slot_sched dut (
    .clk25M      (clk25M),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .speed       (speed),
    .fire_c_req  (fire_c_req),
    .fire_c_hpos (fire_c_hpos),
    .fire_c_ack  (fire_c_ack),
    .fire_e_req  (fire_e_req),
    .fire_e_hpos (fire_e_hpos),
    .fire_e_vpos (fire_e_vpos),
    .fire_e_ack  (fire_e_ack),
    .hit_valid   (hit_valid),
    .hit_slot    (hit_slot),
    .rd_slot     (rd_slot),
    .rd_entry    (rd_entry),
    .active      (active),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #20 clk25M = ~clk25M;

  task automatic tick();
    @(posedge clk25M);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_frame(output int cnt);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic fire_c(input logic [11:0] h);
    int   n;
    exp_t e;
    sb.push_back('{0, {1'b1, 3'b0, 12'd440, h, 12'h0F0}});
    fire_c_hpos = h;
    fire_c_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fire_c_ack && n < 60);
    fire_c_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!fire_c_ack) begin
      failures++;
      $display("FAIL cannon_ack_timeout got=0 exp=1");
    end else begin
      rd_slot = 6'(e.slot);
      #1;
      checks++;
      if (rd_entry !== e.ent) begin
        failures++;
        $display("FAIL cannon_entry got=%h exp=%h", rd_entry, e.ent);
      end
    end
  endtask

  task automatic fire_e(input logic [11:0] h, input logic [11:0] v,
                        input int slot);
    int   n;
    exp_t e;
    sb.push_back('{slot, {1'b1, 3'b0, v, h, 12'hF00}});
    fire_e_hpos = h;
    fire_e_vpos = v;
    fire_e_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fire_e_ack && n < 60);
    fire_e_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!fire_e_ack) begin
      failures++;
      $display("FAIL enemy_ack_timeout slot=%0d got=0 exp=1", slot);
    end else begin
      rd_slot = 6'(e.slot);
      #1;
      checks++;
      if (rd_entry !== e.ent) begin
        failures++;
        $display("FAIL enemy_entry slot=%0d got=%h exp=%h",
                 e.slot, rd_entry, e.ent);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    rd_slot = 6'd0;
    #1;
    checks++;
    if (active !== 40'd0) begin
      failures++;
      $display("FAIL reset_active got=%h exp=0", active);
    end
    checks++;
    if ({busy, overrun, fire_c_ack, fire_e_ack} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {busy, overrun, fire_c_ack, fire_e_ack});
    end
    checks++;
    if (rd_entry !== 40'd0) begin
      failures++;
      $display("FAIL reset_entry got=%h exp=0", rd_entry);
    end
    reset = 1'b0;
  endtask

  task automatic test_cannon();
    int          cnt;
    logic [39:0] exp;
    do_reset();
    fire_c(12'd300);
    tick();
    checks++;
    if (fire_c_ack !== 1'b0) begin
      failures++;
      $display("FAIL cannon_ack_pulse got=%b exp=0", fire_c_ack);
    end
    speed = 4'd4;
    for (int f = 0; f < 2; f++) begin
      do_frame(cnt);
      checks++;
      if (cnt != 40) begin
        failures++;
        $display("FAIL busy_len got=%0d exp=40", cnt);
      end
    end
    exp = {1'b1, 3'b0, 12'd432, 12'd300, 12'h0F0};
    rd_slot = 6'd0;
    #1;
    checks++;
    if (rd_entry !== exp) begin
      failures++;
      $display("FAIL cannon_move got=%h exp=%h", rd_entry, exp);
    end
  endtask

  task automatic test_pool();
    logic acked;
    logic [39:0] full;
    do_reset();
    for (int k = 1; k < 40; k++) fire_e(12'(100 + k), 12'd10, k);
    fire_e_hpos = 12'd999;
    fire_e_vpos = 12'd10;
    fire_e_req  = 1'b1;
    acked = 1'b0;
    repeat (8) begin
      tick();
      if (fire_e_ack) acked = 1'b1;
    end
    fire_e_req = 1'b0;
    checks++;
    if (acked !== 1'b0) begin
      failures++;
      $display("FAIL pool_full_ack got=1 exp=0");
    end
    full = 40'hFF_FFFF_FFFE;
    hit_valid = 1'b1;
    hit_slot  = 6'd45;
    tick();
    hit_valid = 1'b0;
    checks++;
    if (active !== full) begin
      failures++;
      $display("FAIL hit_out_of_range got=%h exp=%h", active, full);
    end
    hit_valid = 1'b1;
    hit_slot  = 6'd7;
    tick();
    hit_valid = 1'b0;
    checks++;
    if (active[7] !== 1'b0) begin
      failures++;
      $display("FAIL hit_slot7 got=%b exp=0", active[7]);
    end
    fire_e(12'd500, 12'd10, 7);
  endtask

  task automatic test_enemy_edge();
    int          cnt;
    logic [39:0] exp;
    do_reset();
    fire_e(12'd1, 12'd457, 1);
    fire_e(12'd2, 12'd456, 2);
    speed = 4'd4;
    do_frame(cnt);
    rd_slot = 6'd1;
    #1;
    checks++;
    if (rd_entry !== 40'd0) begin
      failures++;
      $display("FAIL enemy_exit got=%h exp=0", rd_entry);
    end
    exp = {1'b1, 3'b0, 12'd460, 12'd2, 12'hF00};
    rd_slot = 6'd2;
    #1;
    checks++;
    if (rd_entry !== exp) begin
      failures++;
      $display("FAIL enemy_stay got=%h exp=%h", rd_entry, exp);
    end
  endtask

  task automatic test_cannon_edge();
    int          cnt;
    logic [39:0] exp;
    do_reset();
    fire_c(12'd11);
    speed = 4'd15;
    repeat (29) do_frame(cnt);
    speed = 4'd2;
    do_frame(cnt);
    exp = {1'b1, 3'b0, 12'd3, 12'd11, 12'h0F0};
    rd_slot = 6'd0;
    #1;
    checks++;
    if (rd_entry !== exp) begin
      failures++;
      $display("FAIL cannon_at3 got=%h exp=%h", rd_entry, exp);
    end
    speed = 4'd4;
    do_frame(cnt);
    checks++;
    if (rd_entry !== 40'd0 || active[0] !== 1'b0) begin
      failures++;
      $display("FAIL cannon_exit got=%h exp=0", rd_entry);
    end
    do_reset();
    fire_c(12'd12);
    speed = 4'd15;
    repeat (29) do_frame(cnt);
    speed = 4'd1;
    do_frame(cnt);
    speed = 4'd4;
    do_frame(cnt);
    exp = {1'b1, 3'b0, 12'd0, 12'd12, 12'h0F0};
    rd_slot = 6'd0;
    #1;
    checks++;
    if (rd_entry !== exp) begin
      failures++;
      $display("FAIL cannon_at0 got=%h exp=%h", rd_entry, exp);
    end
    speed = 4'd0;
    do_frame(cnt);
    checks++;
    if (cnt != 40 || rd_entry !== exp) begin
      failures++;
      $display("FAIL speed0 got=%0d/%h exp=40/%h", cnt, rd_entry, exp);
    end
  endtask

  task automatic test_hit_sweep();
    int          cnt;
    logic [39:0] exp;
    do_reset();
    for (int k = 1; k <= 6; k++) fire_e(12'(200 + k), 12'd10, k);
    speed = 4'd1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (5) tick();
    hit_valid = 1'b1;
    hit_slot  = 6'd5;
    tick();
    hit_valid = 1'b0;
    repeat (4) tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got=%b exp=1", overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_len got=%b exp=0", overrun);
    end
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 28) begin
      failures++;
      $display("FAIL sweep_tail got=%0d exp=28", cnt);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL extra_sweep got=%b exp=0", busy);
    end
    rd_slot = 6'd5;
    #1;
    checks++;
    if (rd_entry !== 40'd0) begin
      failures++;
      $display("FAIL hit_in_sweep got=%h exp=0", rd_entry);
    end
    exp = {1'b1, 3'b0, 12'd11, 12'd204, 12'hF00};
    rd_slot = 6'd4;
    #1;
    checks++;
    if (rd_entry !== exp) begin
      failures++;
      $display("FAIL sweep_neighbour got=%h exp=%h", rd_entry, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 10; k++) fire_e(12'(300 + k), 12'd50, k);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (active !== 40'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%b exp=0/0", active, busy);
    end
    fire_e(12'd77, 12'd20, 1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    speed = 4'd0;
    sb.push_back('{0, {1'b1, 3'b0, 12'd440, 12'd33, 12'h0F0}});
    sb.push_back('{1, {1'b1, 3'b0, 12'd44, 12'd55, 12'hF00}});
    fire_c_hpos = 12'd33;
    fire_e_hpos = 12'd55;
    fire_e_vpos = 12'd44;
    fire_c_req  = 1'b1;
    fire_e_req  = 1'b1;
    frame_tick  = 1'b1;
    tick();
    frame_tick  = 1'b0;
    checks++;
    if ({fire_c_ack, fire_e_ack, busy} !== 3'b111) begin
      failures++;
      $display("FAIL dual_accept got=%b exp=111",
               {fire_c_ack, fire_e_ack, busy});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_slot = 6'(e.slot);
      #1;
      checks++;
      if (rd_entry !== e.ent) begin
        failures++;
        $display("FAIL dual_entry slot=%0d got=%h exp=%h",
                 e.slot, rd_entry, e.ent);
      end
    end
    tick();
    checks++;
    if ({fire_c_ack, fire_e_ack} !== 2'b00) begin
      failures++;
      $display("FAIL held_reaccept got=%b exp=00",
               {fire_c_ack, fire_e_ack});
    end
    fire_c_req = 1'b0;
    fire_e_req = 1'b0;
    rd_slot = 6'd45;
    #1;
    checks++;
    if (rd_entry !== 40'd0) begin
      failures++;
      $display("FAIL rd_oob got=%h exp=0", rd_entry);
    end
  endtask

  initial begin
    reset       = 1'b0;
    frame_tick  = 1'b0;
    speed       = 4'd0;
    fire_c_req  = 1'b0;
    fire_c_hpos = '0;
    fire_e_req  = 1'b0;
    fire_e_hpos = '0;
    fire_e_vpos = '0;
    hit_valid   = 1'b0;
    hit_slot    = '0;
    rd_slot     = '0;
    test_reset();
    test_cannon();
    test_pool();
    test_enemy_edge();
    test_cannon_edge();
    test_hit_sweep();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
